// File: rtl/decoder_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : decoder_scan_ctrl_pkg
// Description : Shared constants, state encoding and helpers for the
//               decoder channel scan sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package decoder_scan_ctrl_pkg;

    localparam int NCH   = 8;
    localparam int SEL_W = 3;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DWELL = 1'b1
    } state_t;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [SEL_W-1:0] lowest_set(input logic [NCH-1:0] mask);
        lowest_set = '0;
        for (int i = NCH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                lowest_set = SEL_W'(i);
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/decoder_scan_ctrl_chan_next_find.sv
`default_nettype none
// ============================================================================
// Module      : chan_next_find
// Description : Combinational circular search for the next enabled channel
//               above the current one, plus the lowest enabled channel.
// Revision    : 1.0 - initial release
// ============================================================================
module chan_next_find
    import decoder_scan_ctrl_pkg::*;
(
    input  logic [NCH-1:0]   mask,
    input  logic [SEL_W-1:0] cur,
    output logic [SEL_W-1:0] next,
    output logic             wrap,
    output logic [SEL_W-1:0] first
);

    logic             w_found;
    logic [SEL_W-1:0] w_idx;

    // Offsets 1..NCH-1 from cur, modulo NCH; falls back to cur itself.
    always_comb begin
        next    = cur;
        w_found = 1'b0;
        w_idx   = '0;
        for (int i = 1; i < NCH; i++) begin
            w_idx = cur + SEL_W'(i);
            if (!w_found && mask[w_idx]) begin
                next    = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign wrap  = (next <= cur);
    assign first = lowest_set(mask);

endmodule
`default_nettype wire

// File: rtl/decoder_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : decoder_scan_ctrl
// Description : Steps a registered 3-bit channel select through the enabled
//               channels of a mask, holding each for a programmable dwell.
// Revision    : 1.0 - initial release
// ============================================================================
module decoder_scan_ctrl
    import decoder_scan_ctrl_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               continuous,
    input  logic [NCH-1:0]     ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [SEL_W-1:0]   sel,
    output logic               sel_valid,
    output logic               busy,
    output logic               frame_done
);

    state_t               r_state;
    logic [NCH-1:0]       r_mask;
    logic [DWELL_W-1:0]   r_dwell;
    logic                 r_cont;
    logic [DWELL_W-1:0]   r_cnt;

    state_t               w_state_nxt;
    logic [NCH-1:0]       w_mask_nxt;
    logic [DWELL_W-1:0]   w_dwell_nxt;
    logic                 w_cont_nxt;
    logic [DWELL_W-1:0]   w_cnt_nxt;
    logic [SEL_W-1:0]     w_sel_nxt;
    logic                 w_valid_nxt;
    logic                 w_busy_nxt;
    logic                 w_done_nxt;

    logic [SEL_W-1:0]     w_next_ch;
    logic                 w_wrap;
    logic [SEL_W-1:0]     w_first_ch;
    logic [DWELL_W-1:0]   w_dwell_eff;

    chan_next_find u_chan_next_find (
        .mask  (r_mask),
        .cur   (sel),
        .next  (w_next_ch),
        .wrap  (w_wrap),
        .first (w_first_ch)
    );

    // A zero dwell would stall the counter, so it is promoted to one cycle.
    assign w_dwell_eff = (dwell == '0) ? DWELL_W'(1) : dwell;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_mask     <= '0;
            r_dwell    <= '0;
            r_cont     <= 1'b0;
            r_cnt      <= '0;
            sel        <= '0;
            sel_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_mask     <= w_mask_nxt;
            r_dwell    <= w_dwell_nxt;
            r_cont     <= w_cont_nxt;
            r_cnt      <= w_cnt_nxt;
            sel        <= w_sel_nxt;
            sel_valid  <= w_valid_nxt;
            busy       <= w_busy_nxt;
            frame_done <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_dwell_nxt = r_dwell;
        w_cont_nxt  = r_cont;
        w_cnt_nxt   = r_cnt;
        w_sel_nxt   = sel;
        w_valid_nxt = sel_valid;
        w_busy_nxt  = busy;
        w_done_nxt  = 1'b0;

        if (stop) begin
            w_state_nxt = IDLE;
            w_sel_nxt   = '0;
            w_valid_nxt = 1'b0;
            w_busy_nxt  = 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && (ch_mask != '0)) begin
                        w_state_nxt = DWELL;
                        w_mask_nxt  = ch_mask;
                        w_dwell_nxt = w_dwell_eff;
                        w_cont_nxt  = continuous;
                        w_cnt_nxt   = w_dwell_eff;
                        w_sel_nxt   = lowest_set(ch_mask);
                        w_valid_nxt = 1'b1;
                        w_busy_nxt  = 1'b1;
                    end
                end
                DWELL: begin
                    if (r_cnt == DWELL_W'(1)) begin
                        w_cnt_nxt = r_dwell;
                        if (w_wrap) begin
                            w_done_nxt = 1'b1;
                            if (r_cont) begin
                                w_sel_nxt = w_first_ch;
                            end else begin
                                w_state_nxt = IDLE;
                                w_sel_nxt   = '0;
                                w_valid_nxt = 1'b0;
                                w_busy_nxt  = 1'b0;
                            end
                        end else begin
                            w_sel_nxt = w_next_ch;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt - DWELL_W'(1);
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
